cpu_sequencer: RTL and testbench

Multi-cycle control FSM that sequences the 8-bit program counter, the 32-bit instruction memory, the register file, the ALU and the data memory of the experiment CPU. It gates PC advance, latches the instruction register, decodes the opcode and drives per-state datapath enables. Data-memory access uses a request/acknowledge handshake with a timeout. It sits between `program_counter`/`instruction_memory` and the datapath, replacing the free-running PC increment.

---
 rtl/cpu_sequencer_if.sv | 35 +++
 rtl/cpu_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_cpu_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_if.sv
// cpu_sequencer_if: groups the sequencer's control inputs and datapath
// enables into one bundle.
//   master : the sequencer (takes run/instruction/zero/mem_ack, drives enables)
//   slave  : the datapath / memory side (the opposite directions)
interface cpu_sequencer_if;
   logic        run;
   logic [31:0] instruction;
   logic        zero;
   logic        mem_ack;
   logic        pc_inc;
   logic        pc_load;
   logic [7:0]  pc_target;
   logic        ir_load;
   logic [1:0]  alu_op;
   logic        reg_we;
   logic        wb_sel;
   logic        mem_req;
   logic        mem_we;
   logic [2:0]  state;
   logic        halted;
   logic        fault;
   logic [15:0] instr_count;

   modport master (
      input  run, instruction, zero, mem_ack,
      output pc_inc, pc_load, pc_target, ir_load, alu_op, reg_we, wb_sel,
             mem_req, mem_we, state, halted, fault, instr_count
   );

   modport slave (
      output run, instruction, zero, mem_ack,
      input  pc_inc, pc_load, pc_target, ir_load, alu_op, reg_we, wb_sel,
             mem_req, mem_we, state, halted, fault, instr_count
   );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control FSM for the experiment CPU. Gates PC
// advance, latches the instruction register, decodes the opcode and drives
// the per-state datapath enables, with a req/ack data-memory handshake that
// faults to HALT after MEM_TIMEOUT cycles without an ack.
// Ports:
//   clk    : rising-edge clock
//   rst    : asynchronous, active-low reset
//   seq_if : cpu_sequencer_if.master (run/instruction/zero/mem_ack in;
//            PC, IR, ALU, register-file and memory enables plus status out)
module cpu_sequencer #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   cpu_sequencer_if.master   seq_if
);

   localparam int TW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LOAD  = 6'b000100;
   localparam logic [5:0] OP_STORE = 6'b000101;
   localparam logic [5:0] OP_BEQ   = 6'b000110;
   localparam logic [5:0] OP_JMP   = 6'b000111;
   localparam logic [5:0] OP_HALT  = 6'b111111;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   // Only the IR fields the sequencer decodes are kept: IR[31:24] holds both
   // the jump target and the R-type funct (IR[31:26]); IR[5:0] is the opcode.
   state_t      state_q, state_d;
   logic [7:0]  ir_hi_q, ir_hi_d;
   logic [5:0]  ir_op_q, ir_op_d;
   logic [7:0]  pc_target_q, pc_target_d;
   logic        fault_q, fault_d;
   logic [15:0] cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic       pc_inc, pc_load, ir_load, reg_we, wb_sel, mem_req, mem_we;
   logic [1:0] alu_op;
   logic       retire;
   logic [5:0] funct;
   logic       legal;

   assign funct = ir_hi_q[7:2];

   always_comb begin
      legal = 1'b0;
      case (ir_op_q)
         OP_RTYPE: legal = (funct[5:2] == 4'd0);
         OP_LOAD, OP_STORE, OP_BEQ, OP_JMP, OP_HALT: legal = 1'b1;
         default:  legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         ir_hi_q     <= '0;
         ir_op_q     <= '0;
         pc_target_q <= '0;
         fault_q     <= 1'b0;
         cnt_q       <= '0;
         tmo_q       <= '0;
      end else begin
         state_q     <= state_d;
         ir_hi_q     <= ir_hi_d;
         ir_op_q     <= ir_op_d;
         pc_target_q <= pc_target_d;
         fault_q     <= fault_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      ir_hi_d     = ir_hi_q;
      ir_op_d     = ir_op_q;
      pc_target_d = pc_target_q;
      fault_d     = fault_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      retire      = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      ir_load     = 1'b0;
      alu_op      = 2'b00;
      reg_we      = 1'b0;
      wb_sel      = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (seq_if.run) state_d = S_FETCH;
         end
         S_FETCH: begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            ir_hi_d = seq_if.instruction[31:24];
            ir_op_d = seq_if.instruction[5:0];
            state_d = S_DECODE;
         end
         S_DECODE: begin
            pc_target_d = ir_hi_q;
            if (ir_op_q == OP_HALT) begin
               state_d = S_HALT;
            end else if (!legal) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (ir_op_q)
               OP_RTYPE: begin
                  alu_op  = funct[1:0];
                  state_d = S_WB;
               end
               OP_LOAD, OP_STORE: begin
                  state_d = S_MEM;
                  tmo_d   = '0;
               end
               // BEQ's pc_load follows zero combinationally within EXEC.
               OP_BEQ: begin
                  pc_load = seq_if.zero;
                  retire  = 1'b1;
               end
               OP_JMP: begin
                  pc_load = 1'b1;
                  retire  = 1'b1;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (ir_op_q == OP_STORE);
            // An ack in the final allowed cycle takes priority over the timeout.
            if (seq_if.mem_ack) begin
               if (ir_op_q == OP_LOAD) state_d = S_WB;
               else                    retire  = 1'b1;
            end else if (tmo_q == TMO_LAST) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WB: begin
            reg_we = 1'b1;
            wb_sel = (ir_op_q == OP_LOAD);
            retire = 1'b1;
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
         state_d = seq_if.run ? S_FETCH : S_IDLE;
      end
   end

   assign seq_if.pc_inc      = pc_inc;
   assign seq_if.pc_load     = pc_load;
   assign seq_if.pc_target   = pc_target_q;
   assign seq_if.ir_load     = ir_load;
   assign seq_if.alu_op      = alu_op;
   assign seq_if.reg_we      = reg_we;
   assign seq_if.wb_sel      = wb_sel;
   assign seq_if.mem_req     = mem_req;
   assign seq_if.mem_we      = mem_we;
   assign seq_if.state       = state_q;
   assign seq_if.halted      = (state_q == S_HALT);
   assign seq_if.fault       = fault_q;
   assign seq_if.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: directed-vector bench for cpu_sequencer. Walks R-type,
// LOAD/STORE handshakes, BEQ/JMP, run deassert, illegal opcode, memory
// timeout (and ack-at-timeout), HALT opcode and reset during MEM.
module tb_cpu_sequencer;

   localparam logic [31:0] ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2,
                           ST_EXEC = 3, ST_MEM = 4, ST_WB = 5, ST_HALT = 6;

   localparam logic [31:0] I_SUB   = 32'h0400_0000;
   localparam logic [31:0] I_OR    = 32'h0C00_0000;
   localparam logic [31:0] I_LOAD  = 32'h0000_0004;
   localparam logic [31:0] I_STORE = 32'h0000_0005;
   localparam logic [31:0] I_BEQ   = 32'h2000_0006;
   localparam logic [31:0] I_JMP   = 32'h4400_0007;
   localparam logic [31:0] I_HALT  = 32'h0000_003F;
   localparam logic [31:0] I_ILL   = 32'h0000_000A;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cpu_sequencer_if bus ();

   cpu_sequencer #(.MEM_TIMEOUT(15)) dut (
      .clk    (clk),
      .rst    (rst),
      .seq_if (bus)
   );

   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [31:0] enables();
      return {23'd0, bus.pc_inc, bus.pc_load, bus.ir_load, bus.reg_we, bus.wb_sel,
              bus.mem_req, bus.mem_we, bus.halted, bus.fault};
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int req_cycles;
      rst = 1'b0;
      bus.run = 1'b0;
      bus.instruction = '0;
      bus.zero = 1'b0;
      bus.mem_ack = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_state", bus.state, ST_IDLE);
      check("rst_enables", enables(), 0);
      check("rst_alu_op", bus.alu_op, 0);
      check("rst_pc_target", bus.pc_target, 0);
      check("rst_count", bus.instr_count, 0);

      // R-type sub
      rst = 1'b1;
      bus.run = 1'b1;
      bus.instruction = I_SUB;
      #1 check("idle_before_edge", bus.state, ST_IDLE);
      tick();
      check("sub_fetch", bus.state, ST_FETCH);
      check("sub_fetch_pcinc", bus.pc_inc, 1);
      check("sub_fetch_irload", bus.ir_load, 1);
      tick();
      check("sub_decode", bus.state, ST_DECODE);
      check("sub_decode_pcinc", bus.pc_inc, 0);
      tick();
      check("sub_exec", bus.state, ST_EXEC);
      check("sub_alu_op", bus.alu_op, 1);
      tick();
      check("sub_wb", bus.state, ST_WB);
      check("sub_wb_regwe", bus.reg_we, 1);
      check("sub_wb_sel", bus.wb_sel, 0);
      check("sub_count_wb", bus.instr_count, 0);
      tick();
      check("sub_retire_fetch", bus.state, ST_FETCH);
      check("sub_count", bus.instr_count, 1);

      // LOAD, ack in 3rd MEM cycle
      bus.instruction = I_LOAD;
      tick();
      tick();
      check("load_exec", bus.state, ST_EXEC);
      check("load_alu_add", bus.alu_op, 0);
      req_cycles = 0;
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("load_mem_state", bus.state, ST_MEM);
         check("load_mem_we", bus.mem_we, 0);
         if (bus.mem_req) req_cycles++;
         if (i == 3) bus.mem_ack = 1'b1;
      end
      tick();
      bus.mem_ack = 1'b0;
      check("load_req_cycles", req_cycles, 3);
      check("load_wb", bus.state, ST_WB);
      check("load_wb_req_low", bus.mem_req, 0);
      check("load_wb_regwe", bus.reg_we, 1);
      check("load_wb_sel", bus.wb_sel, 1);
      tick();
      check("load_retire", bus.state, ST_FETCH);
      check("load_count", bus.instr_count, 2);

      // STORE, immediate ack
      bus.instruction = I_STORE;
      tick();
      tick();
      check("store_exec", bus.state, ST_EXEC);
      tick();
      check("store_mem", bus.state, ST_MEM);
      check("store_req", bus.mem_req, 1);
      check("store_we", bus.mem_we, 1);
      bus.mem_ack = 1'b1;
      tick();
      bus.mem_ack = 1'b0;
      check("store_retire", bus.state, ST_FETCH);
      check("store_req_low", bus.mem_req, 0);
      check("store_count", bus.instr_count, 3);

      // BEQ to 0x20
      bus.instruction = I_BEQ;
      tick();
      tick();
      bus.zero = 1'b1;
      #1;
      check("beq_exec", bus.state, ST_EXEC);
      check("beq_taken_load", bus.pc_load, 1);
      check("beq_taken_no_inc", bus.pc_inc, 0);
      check("beq_target", bus.pc_target, 32'h20);
      bus.zero = 1'b0;
      #1 check("beq_not_taken", bus.pc_load, 0);
      tick();
      check("beq_retire", bus.state, ST_FETCH);
      check("beq_count", bus.instr_count, 4);

      // JMP to 0x44
      bus.instruction = I_JMP;
      tick();
      tick();
      check("jmp_load", bus.pc_load, 1);
      check("jmp_target", bus.pc_target, 32'h44);
      tick();
      check("jmp_retire", bus.state, ST_FETCH);
      check("jmp_count", bus.instr_count, 5);

      // run dropped mid-instruction: OR completes, then IDLE
      bus.instruction = I_OR;
      bus.run = 1'b0;
      tick();
      tick();
      check("or_alu_op", bus.alu_op, 3);
      tick();
      check("or_wb", bus.state, ST_WB);
      tick();
      check("run_low_idle", bus.state, ST_IDLE);
      check("or_count", bus.instr_count, 6);
      tick();
      check("idle_stays", bus.state, ST_IDLE);
      bus.run = 1'b1;
      tick();
      check("idle_to_fetch", bus.state, ST_FETCH);

      // Illegal opcode
      bus.instruction = I_ILL;
      tick();
      tick();
      check("ill_halt", bus.state, ST_HALT);
      check("ill_fault", bus.fault, 1);
      check("ill_halted", bus.halted, 1);
      bus.run = 1'b0;
      tick();
      bus.run = 1'b1;
      tick();
      tick();
      check("halt_absorbing", bus.state, ST_HALT);
      check("halt_no_pcinc", bus.pc_inc, 0);
      check("halt_count", bus.instr_count, 6);

      // LOAD timeout
      rst = 1'b0;
      #1;
      check("rst_clears_fault", bus.fault, 0);
      check("rst_clears_state", bus.state, ST_IDLE);
      tick();
      rst = 1'b1;
      bus.instruction = I_LOAD;
      tick();
      tick();
      tick();
      for (int i = 1; i <= 15; i++) begin
         tick();
         check("tmo_mem_req", {bus.state[2:0], bus.mem_req}, {3'd4, 1'b1});
      end
      tick();
      check("tmo_halt", bus.state, ST_HALT);
      check("tmo_fault", bus.fault, 1);
      check("tmo_req_low", bus.mem_req, 0);

      // Ack on the 15th MEM cycle beats the timeout
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      tick();
      tick();
      for (int i = 1; i <= 15; i++) begin
         tick();
         if (i == 15) bus.mem_ack = 1'b1;
      end
      tick();
      bus.mem_ack = 1'b0;
      check("ack_last_wb", bus.state, ST_WB);
      check("ack_last_nofault", bus.fault, 0);
      tick();
      check("ack_last_count", bus.instr_count, 1);

      // Reset during MEM
      bus.instruction = I_STORE;
      tick();
      tick();
      tick();
      check("midmem_req", bus.mem_req, 1);
      rst = 1'b0;
      #1;
      check("midmem_req_drop", bus.mem_req, 0);
      check("midmem_count", bus.instr_count, 0);
      check("midmem_state", bus.state, ST_IDLE);
      tick();
      rst = 1'b1;

      // HALT opcode: HALT after 2 cycles, no fault
      bus.instruction = I_HALT;
      tick();
      tick();
      tick();
      check("halt_op_state", bus.state, ST_HALT);
      check("halt_op_nofault", bus.fault, 0);
      check("halt_op_halted", bus.halted, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
